// File: rtl/hex_inverter_emulator_if.sv
// Configuration handshake and status bundle between the tester-side controller
// and the hex inverter emulator.
interface hex_inverter_emulator_if #(
    parameter int DELAY_W = 8
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [11:0]        cfg_fault;
    logic [DELAY_W-1:0] cfg_delay;
    logic [5:0]         fault_flags;
    logic               busy;

    modport master (
        output cfg_valid, cfg_fault, cfg_delay,
        input  cfg_ready, fault_flags, busy
    );

    modport slave (
        input  cfg_valid, cfg_fault, cfg_delay,
        output cfg_ready, fault_flags, busy
    );
endinterface

// File: rtl/hex_inverter_emulator.sv
// Six-channel 7404-style inverter model with per-channel fault modes and an
// inertial propagation delay, reconfigurable through a two-state handshake FSM.
module hex_inverter_emulator #(
    parameter int DELAY_W       = 8,
    parameter int DEFAULT_DELAY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic A4,
    input  logic A5,
    input  logic A6,
    output logic op1,
    output logic op2,
    output logic op3,
    output logic op4,
    output logic op5,
    output logic op6,
    hex_inverter_emulator_if.slave cfg
);
    typedef enum logic {IDLE, APPLY} state_e;

    state_e                  state_q, state_d;
    logic [5:0]              pin_in;
    logic [5:0]              sync0_q, sync1_q;
    logic [11:0]             mode_q, mode_d;
    logic [DELAY_W-1:0]      delay_q, delay_d;
    logic [5:0]              flags_q, flags_d;
    logic [5:0]              pend_q, pend_d;
    logic [5:0][DELAY_W-1:0] cnt_q, cnt_d;
    logic [5:0]              op_q, op_d;
    logic [5:0]              target;
    logic                    accept;

    function automatic logic target_f(input logic [1:0] mode, input logic a);
        logic t;
        unique case (mode)
            2'b00: t = ~a;
            2'b01: t = 1'b0;
            2'b10: t = 1'b1;
            2'b11: t = a;
        endcase
        return t;
    endfunction

    function automatic logic [5:0] flags_f(input logic [11:0] mode);
        logic [5:0] f;
        for (int i = 0; i < 6; i++) f[i] = |mode[2*i +: 2];
        return f;
    endfunction

    assign pin_in = {A6, A5, A4, A3, A2, A1};
    assign accept = (state_q == IDLE) && cfg.cfg_valid;

    // Configuration FSM: accept in IDLE, then one APPLY cycle with channels frozen.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        delay_d = delay_q;
        flags_d = flags_q;
        unique case (state_q)
            IDLE: begin
                if (cfg.cfg_valid) begin
                    state_d = APPLY;
                    mode_d  = cfg.cfg_fault;
                    delay_d = cfg.cfg_delay;
                    flags_d = flags_f(cfg.cfg_fault);
                end
            end
            APPLY: state_d = IDLE;
        endcase
    end

    // Channel evaluation runs only in IDLE cycles without an accept, so a
    // reconfiguration cancels pending edges and restarts them with the new delay.
    always_comb begin
        pend_d = pend_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        for (int i = 0; i < 6; i++) target[i] = target_f(mode_q[2*i +: 2], sync1_q[i]);
        if (accept) begin
            pend_d = '0;
        end else if (state_q == IDLE) begin
            for (int i = 0; i < 6; i++) begin
                if (!pend_q[i]) begin
                    if (target[i] != op_q[i]) begin
                        if (delay_q == '0) begin
                            op_d[i] = target[i];
                        end else begin
                            cnt_d[i]  = delay_q;
                            pend_d[i] = 1'b1;
                        end
                    end
                end else if (target[i] == op_q[i]) begin
                    pend_d[i] = 1'b0;
                end else if (cnt_q[i] == DELAY_W'(1)) begin
                    op_d[i]   = target[i];
                    pend_d[i] = 1'b0;
                end else begin
                    cnt_d[i] = cnt_q[i] - DELAY_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sync0_q <= '0;
            sync1_q <= '0;
            mode_q  <= '0;
            delay_q <= DELAY_W'(DEFAULT_DELAY);
            flags_q <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '1;
        end else begin
            state_q <= state_d;
            sync0_q <= pin_in;
            sync1_q <= sync0_q;
            mode_q  <= mode_d;
            delay_q <= delay_d;
            flags_q <= flags_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    assign {op6, op5, op4, op3, op2, op1} = op_q;
    assign cfg.cfg_ready   = (state_q == IDLE);
    assign cfg.fault_flags = flags_q;
    assign cfg.busy        = |pend_q;
endmodule

// File: tb/tb_hex_inverter_emulator.sv
// Directed bench for hex_inverter_emulator: expectations are queued with the
// cycle they fall due and compared as the clock reaches that cycle.
module tb_hex_inverter_emulator;
    localparam int DW = 8;

    typedef struct {
        int         due;
        int         kind;
        logic [5:0] exp;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] a;
    logic [5:0] op;
    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;

    hex_inverter_emulator_if #(.DELAY_W(DW)) bus ();

    hex_inverter_emulator #(.DELAY_W(DW), .DEFAULT_DELAY(4)) dut (
        .clk(clk), .rst(rst),
        .A1(a[0]), .A2(a[1]), .A3(a[2]), .A4(a[3]), .A5(a[4]), .A6(a[5]),
        .op1(op[0]), .op2(op[1]), .op3(op[2]), .op4(op[3]), .op5(op[4]), .op6(op[5]),
        .cfg(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [5:0] observe(input int kind);
        logic [5:0] v;
        case (kind)
            0:       v = op;
            1:       v = {5'b0, bus.busy};
            2:       v = {5'b0, bus.cfg_ready};
            default: v = bus.fault_flags;
        endcase
        return v;
    endfunction

    task automatic push(input int dly, input int kind, input logic [5:0] exp, input string tag);
        exp_t e;
        e.due  = cyc + dly;
        e.kind = kind;
        e.exp  = exp;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                chk(sb[i].tag, observe(sb[i].kind), sb[i].exp);
                sb.delete(i);
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst           = 1'b1;
        a             = '0;
        bus.cfg_valid = 1'b0;
        bus.cfg_fault = '0;
        bus.cfg_delay = '0;
        #1;
        chk("rst_op", op, 6'h3F);
        steps(2);
        rst = 1'b0;
        chk("idle_op", op, 6'h3F);
        chk("idle_busy", {5'b0, bus.busy}, 6'd0);
        chk("idle_ready", {5'b0, bus.cfg_ready}, 6'd1);
        chk("idle_flags", bus.fault_flags, 6'b000000);
        push(3, 0, 6'h3F, "idle_op_later");
        steps(4);

        // Default delay 4: A1 rises, op1 falls 7 edges after the drive.
        a[0] = 1'b1;
        push(2, 1, 6'd0, "d4_busy_pre");
        push(3, 1, 6'd1, "d4_busy_start");
        push(6, 1, 6'd1, "d4_busy_end");
        push(6, 0, 6'h3F, "d4_op_hold");
        push(7, 0, 6'h3E, "d4_op_fall");
        push(7, 1, 6'd0, "d4_busy_clear");
        steps(9);

        // Three-cycle pulse on A2 is shorter than D+1 and must be swallowed.
        a[1] = 1'b1;
        push(3, 1, 6'd1, "pulse_busy");
        push(5, 1, 6'd1, "pulse_busy_hold");
        push(6, 1, 6'd0, "pulse_cancel");
        push(4, 0, 6'h3E, "pulse_op_mid");
        push(8, 0, 6'h3E, "pulse_swallow");
        push(10, 0, 6'h3E, "pulse_swallow_late");
        steps(3);
        a[1] = 1'b0;
        steps(8);

        // Fault modes with delay 0: ch4 stuck-0, ch5 stuck-1, ch6 non-inverting.
        chk("cfg_ready_before", {5'b0, bus.cfg_ready}, 6'd1);
        bus.cfg_valid = 1'b1;
        bus.cfg_fault = 12'b11_10_01_00_00_00;
        bus.cfg_delay = 8'd0;
        a[5:2]        = 4'b1111;
        push(1, 2, 6'd0, "cfg_ready_apply");
        push(2, 2, 6'd1, "cfg_ready_back");
        push(1, 3, 6'b111000, "cfg_flags");
        push(2, 0, 6'h3E, "cfg_no_jump");
        push(3, 0, 6'b110010, "cfg_modes");
        step();
        bus.cfg_valid = 1'b0;
        steps(4);

        // Back to good modes with zero delay and all inputs low.
        bus.cfg_valid = 1'b1;
        bus.cfg_fault = '0;
        bus.cfg_delay = 8'd0;
        a             = '0;
        push(1, 3, 6'd0, "flags_clear");
        push(3, 0, 6'h3F, "restore_op");
        step();
        bus.cfg_valid = 1'b0;
        steps(4);

        // Delay 20 transition interrupted by reset.
        bus.cfg_valid = 1'b1;
        bus.cfg_delay = 8'd20;
        step();
        bus.cfg_valid = 1'b0;
        step();
        a[0] = 1'b1;
        steps(5);
        chk("d20_busy", {5'b0, bus.busy}, 6'd1);
        rst = 1'b1;
        #1;
        chk("midrst_op", op, 6'h3F);
        chk("midrst_busy", {5'b0, bus.busy}, 6'd0);
        chk("midrst_ready", {5'b0, bus.cfg_ready}, 6'd1);
        step();
        rst = 1'b0;
        push(6, 0, 6'h3F, "rst_delay_hold");
        push(7, 0, 6'h3E, "rst_delay_fall");
        steps(8);

        // Return A1 low, then delay 10 with a reconfigure to delay 2 mid-transition.
        a[0] = 1'b0;
        push(7, 0, 6'h3F, "op1_rise");
        steps(8);
        bus.cfg_valid = 1'b1;
        bus.cfg_delay = 8'd10;
        step();
        bus.cfg_valid = 1'b0;
        step();
        a[0] = 1'b1;
        steps(5);
        chk("d10_pending", {5'b0, bus.busy}, 6'd1);
        bus.cfg_valid = 1'b1;
        bus.cfg_delay = 8'd2;
        push(1, 1, 6'd0, "cancel_busy");
        push(3, 1, 6'd1, "restart_busy");
        push(4, 0, 6'h3F, "restart_hold");
        push(5, 0, 6'h3E, "restart_fall");
        step();
        bus.cfg_valid = 1'b0;
        steps(5);

        // cfg_valid held across APPLY is accepted again on the next IDLE cycle.
        bus.cfg_valid = 1'b1;
        push(1, 2, 6'd0, "hold_apply");
        push(2, 2, 6'd1, "hold_idle");
        push(3, 2, 6'd0, "hold_reaccept");
        push(4, 2, 6'd1, "hold_final");
        steps(3);
        bus.cfg_valid = 1'b0;
        steps(2);

        chk("sb_empty", 6'(sb.size()), 6'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
